rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of register-file write data.
REQ-002 Parameter STARVE_LIMIT, default 4, cycles a buffered request may wait before it overrides the ALU (legal range 1..7).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 alu_we  input  1  core requests a write this cycle (unbuffered).
REQ-006 alu_rd  input  5  ALU destination register, already selected by the rd mux.
REQ-007 alu_data  input  DATA_W  ALU write data.
REQ-008 alu_stall  output  1  combinational; ALU request not accepted this cycle, core holds alu_we/alu_rd/alu_data unchanged.
REQ-009 mem_valid  input  1  load-return write offered.
REQ-010 mem_rd  input  5  load destination register.
REQ-011 mem_data  input  DATA_W  load data.
REQ-012 mem_ready  output  1  mem buffer empty; transfer occurs on mem_valid & mem_ready.
REQ-013 io_valid  input  1  IN-instruction write offered.
REQ-014 io_rd  input  5  IN destination register.
REQ-015 io_data  input  DATA_W  input-port data.
REQ-016 io_ready  output  1  io buffer empty; transfer occurs on io_valid & io_ready.
REQ-017 rf_we  output  1  registered write enable to register file.
REQ-018 rf_waddr  output  5  registered write address.
REQ-019 rf_wdata  output  DATA_W  registered write data.

Function
REQ-020 mem and io each SHALL own a one-entry buffer (rd, data, full flag, 3-bit wait counter).
REQ-021 ready SHALL equal !full of that buffer; no same-cycle bypass: a buffer freed in cycle N accepts again no earlier than cycle N+1.
REQ-022 On accept, buffer SHALL capture rd/data, set full, clear wait counter.
REQ-023 Starving: buffer full and wait counter >= STARVE_LIMIT.
REQ-024 Grant priority each cycle: starving mem > starving io > alu_we > full mem > full io > none.
REQ-025 alu_stall SHALL be 1 exactly when alu_we=1 and a starving buffer is granted; otherwise 0.
REQ-026 Granted buffer SHALL clear full at the clock edge ending the grant cycle.
REQ-027 Each full, non-granted buffer SHALL increment its wait counter per cycle, saturating at STARVE_LIMIT.
REQ-028 Grant in cycle N SHALL appear on rf_we/rf_waddr/rf_wdata in cycle N+1 (latency 1); no grant -> rf_we=0 next cycle, rf_waddr/rf_wdata hold.
REQ-029 Grant with destination 5'd0 SHALL consume the request but drive rf_we=0 (r0 never written); rf_waddr/rf_wdata still update.
REQ-030 At most one write per cycle; no request SHALL be dropped or duplicated.
REQ-031 mem_valid/io_valid while not ready SHALL have no effect; requester holds its payload.

Reset
REQ-032 reset=1 at a rising edge SHALL clear both full flags and wait counters, rf_we=0, rf_waddr=0, rf_wdata=0, regardless of state.
REQ-033 During reset cycles mem_ready/io_ready SHALL be 0 and alu_stall SHALL be 0; a request in flight when reset asserts is discarded.
REQ-034 First accept/grant possible in the first cycle after reset deasserts.

Verification
REQ-035 alu_we=1, alu_rd=5, alu_data=0x1234 one cycle, buffers empty -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, alu_stall=0.
REQ-036 mem accept rd=7 data=0xAAAA while alu_we held 1 continuously (STARVE_LIMIT=4) -> ALU granted 4 cycles, then 1 cycle alu_stall=1 with mem write rd=7 on rf next cycle, mem_ready=1 after.
REQ-037 mem and io both accept same cycle, alu_we=0 -> writes in order mem then io on consecutive cycles; io_ready=0 until its grant.
REQ-038 io accept rd=0 data=0xFFFF -> buffer consumed, rf_we stays 0, io_ready returns to 1.
REQ-039 Both buffers full and starving, alu_we=1 -> mem granted, then io, alu_stall=1 both cycles, then ALU granted.
REQ-040 reset asserted with both buffers full and alu_we=1 -> next cycle rf_we=0, outputs 0, no held write emitted after reset release.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter_if
//  Description : Bundle of the three write requesters (ALU, load return, IN
//                port) and the register-file write port of rf_write_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rf_write_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              alu_we;
    logic [4:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_stall;

    logic              mem_valid;
    logic [4:0]        mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              io_valid;
    logic [4:0]        io_rd;
    logic [DATA_W-1:0] io_data;
    logic              io_ready;

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // Requester / register-file side
    modport master (
        output alu_we, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               io_valid, io_rd, io_data,
        input  alu_stall, mem_ready, io_ready, rf_we, rf_waddr, rf_wdata
    );

    // Arbiter side
    modport slave (
        input  alu_we, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
               io_valid, io_rd, io_data,
        output alu_stall, mem_ready, io_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_arbiter
//  Description : Arbitrates a single register-file write port between the
//                unbuffered ALU and one-entry buffers for load returns and
//                IN-port data. Buffered requests that wait too long override
//                the ALU, which then stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    rf_write_arbiter_if.slave bus
);

    localparam logic [2:0] c_STARVE = 3'(STARVE_LIMIT);

    logic              r_mem_full;
    logic [4:0]        r_mem_rd;
    logic [DATA_W-1:0] r_mem_data;
    logic [2:0]        r_mem_wait;

    logic              r_io_full;
    logic [4:0]        r_io_rd;
    logic [DATA_W-1:0] r_io_data;
    logic [2:0]        r_io_wait;

    logic              r_rf_we;
    logic [4:0]        r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    logic              w_mem_starve;
    logic              w_io_starve;
    logic              w_gnt_mem;
    logic              w_gnt_io;
    logic              w_gnt_alu;
    logic              w_any_gnt;
    logic [4:0]        w_gnt_rd;
    logic [DATA_W-1:0] w_gnt_data;
    logic              w_mem_accept;
    logic              w_io_accept;

    // Fixed-priority grant; nothing is granted while reset is held
    always_comb begin
        w_mem_starve = r_mem_full && (r_mem_wait >= c_STARVE);
        w_io_starve  = r_io_full  && (r_io_wait  >= c_STARVE);
        w_gnt_mem    = 1'b0;
        w_gnt_io     = 1'b0;
        w_gnt_alu    = 1'b0;
        w_gnt_rd     = 5'd0;
        w_gnt_data   = '0;
        if (!reset) begin
            if (w_mem_starve)      w_gnt_mem = 1'b1;
            else if (w_io_starve)  w_gnt_io  = 1'b1;
            else if (bus.alu_we)   w_gnt_alu = 1'b1;
            else if (r_mem_full)   w_gnt_mem = 1'b1;
            else if (r_io_full)    w_gnt_io  = 1'b1;
        end
        if (w_gnt_mem) begin
            w_gnt_rd   = r_mem_rd;
            w_gnt_data = r_mem_data;
        end else if (w_gnt_io) begin
            w_gnt_rd   = r_io_rd;
            w_gnt_data = r_io_data;
        end else if (w_gnt_alu) begin
            w_gnt_rd   = bus.alu_rd;
            w_gnt_data = bus.alu_data;
        end
        w_any_gnt    = w_gnt_mem | w_gnt_io | w_gnt_alu;
        w_mem_accept = bus.mem_valid && !r_mem_full && !reset;
        w_io_accept  = bus.io_valid  && !r_io_full  && !reset;
    end

    // Ready only when empty; a freed buffer reopens the following cycle
    assign bus.mem_ready = !r_mem_full && !reset;
    assign bus.io_ready  = !r_io_full  && !reset;
    assign bus.alu_stall = bus.alu_we && !reset && (w_mem_starve || w_io_starve);
    assign bus.rf_we     = r_rf_we;
    assign bus.rf_waddr  = r_rf_waddr;
    assign bus.rf_wdata  = r_rf_wdata;

    // Load-return buffer: capture, age while passed over, release on grant
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_full <= 1'b0;
            r_mem_wait <= 3'd0;
            r_mem_rd   <= 5'd0;
            r_mem_data <= '0;
        end else if (w_gnt_mem) begin
            r_mem_full <= 1'b0;
        end else if (r_mem_full) begin
            if (r_mem_wait < c_STARVE) r_mem_wait <= r_mem_wait + 3'd1;
        end else if (w_mem_accept) begin
            r_mem_full <= 1'b1;
            r_mem_wait <= 3'd0;
            r_mem_rd   <= bus.mem_rd;
            r_mem_data <= bus.mem_data;
        end
    end

    // IN-port buffer: same behaviour as the load-return buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_io_full <= 1'b0;
            r_io_wait <= 3'd0;
            r_io_rd   <= 5'd0;
            r_io_data <= '0;
        end else if (w_gnt_io) begin
            r_io_full <= 1'b0;
        end else if (r_io_full) begin
            if (r_io_wait < c_STARVE) r_io_wait <= r_io_wait + 3'd1;
        end else if (w_io_accept) begin
            r_io_full <= 1'b1;
            r_io_wait <= 3'd0;
            r_io_rd   <= bus.io_rd;
            r_io_data <= bus.io_data;
        end
    end

    // Register the granted write; r0 writes are consumed but not enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= '0;
        end else if (w_any_gnt) begin
            r_rf_we    <= (w_gnt_rd != 5'd0);
            r_rf_waddr <= w_gnt_rd;
            r_rf_wdata <= w_gnt_data;
        end else begin
            r_rf_we    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_write_arbiter
//  Description : Self-checking bench for rf_write_arbiter: directed scenarios
//                with literal expectations followed by randomized traffic
//                compared every cycle against a timestamp-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    localparam int c_LIMIT = 4;

    logic clk;
    logic reset;

    rf_write_arbiter_if #(.DATA_W(32)) bus();

    rf_write_arbiter #(.DATA_W(32), .STARVE_LIMIT(c_LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: each buffer remembers the cycle it became full;
    // its wait is simply "cycles since then", starving at >= c_LIMIT.
    // ------------------------------------------------------------------
    int          cyc = 0;
    bit          m_full, i_full;
    logic [4:0]  m_rd, i_rd;
    logic [31:0] m_data, i_data;
    int          m_acc, i_acc;
    bit          have_exp = 0;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_stall, e_mr, e_ir;
    bit          m_st, i_st;
    int          rk_m, rk_i, rk_a, gsel;
    bit          alu_done = 1, mem_xfer = 0, io_xfer = 0;

    // One compare per cycle against the model, then advance the model
    always @(negedge clk) begin
        cyc++;
        gsel = 0;
        if (reset) begin
            e_stall = 0; e_mr = 0; e_ir = 0;
        end else begin
            m_st = m_full && (cyc - m_acc >= c_LIMIT);
            i_st = i_full && (cyc - i_acc >= c_LIMIT);
            rk_m = m_full ? (m_st ? 0 : 3) : 9;
            rk_i = i_full ? (i_st ? 1 : 4) : 9;
            rk_a = bus.alu_we ? 2 : 9;
            if (rk_m < 9 && rk_m < rk_i && rk_m < rk_a) gsel = 1;
            else if (rk_i < 9 && rk_i < rk_a)           gsel = 2;
            else if (rk_a < 9)                          gsel = 3;
            e_stall = bus.alu_we && (m_st || i_st);
            e_mr = !m_full;
            e_ir = !i_full;
        end
        check("alu_stall", bus.alu_stall, e_stall);
        check("mem_ready", bus.mem_ready, e_mr);
        check("io_ready",  bus.io_ready,  e_ir);
        if (have_exp) begin
            check("rf_we",    bus.rf_we,    e_we);
            check("rf_waddr", bus.rf_waddr, e_addr);
            check("rf_wdata", bus.rf_wdata, e_data);
        end
        alu_done = !bus.alu_we || !e_stall || reset;
        mem_xfer = bus.mem_valid && e_mr;
        io_xfer  = bus.io_valid  && e_ir;
        have_exp = 1;
        if (reset) begin
            m_full = 0; i_full = 0;
            e_we = 0; e_addr = 0; e_data = 0;
        end else begin
            case (gsel)
                1: begin e_we = (m_rd != 0); e_addr = m_rd; e_data = m_data; m_full = 0; end
                2: begin e_we = (i_rd != 0); e_addr = i_rd; e_data = i_data; i_full = 0; end
                3: begin e_we = (bus.alu_rd != 0); e_addr = bus.alu_rd; e_data = bus.alu_data; end
                default: e_we = 0;
            endcase
            if (mem_xfer) begin m_full = 1; m_rd = bus.mem_rd; m_data = bus.mem_data; m_acc = cyc + 1; end
            if (io_xfer)  begin i_full = 1; i_rd = bus.io_rd;  i_data = bus.io_data;  i_acc = cyc + 1; end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    int          first;
    logic [7:0]  hist;
    logic [4:0]  w6, w7;

    initial begin
        reset = 1;
        bus.alu_we = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
        bus.io_valid = 0; bus.io_rd = 0; bus.io_data = 0;
        repeat (3) nxt();
        reset = 0;

        // Single ALU write, buffers empty
        bus.alu_we = 1; bus.alu_rd = 5; bus.alu_data = 32'h1234;
        smp(); check("t35_stall", bus.alu_stall, 0);
        nxt(); bus.alu_we = 0;
        smp();
        check("t35_we", bus.rf_we, 1);
        check("t35_addr", bus.rf_waddr, 5);
        check("t35_data", bus.rf_wdata, 32'h1234);

        // Load buffered while ALU busy: overrides after the starve limit
        nxt();
        bus.alu_we = 1; bus.alu_rd = 3; bus.alu_data = 32'h55;
        bus.mem_valid = 1; bus.mem_rd = 7; bus.mem_data = 32'hAAAA;
        first = -1;
        for (int i = 0; i < 6; i++) begin
            smp();
            if (bus.alu_stall && first < 0) first = i;
            nxt();
            bus.mem_valid = 0;
        end
        check("t36_stall_cycle", first, 5);
        smp();
        check("t36_we", bus.rf_we, 1);
        check("t36_addr", bus.rf_waddr, 7);
        check("t36_data", bus.rf_wdata, 32'hAAAA);
        check("t36_mem_ready", bus.mem_ready, 1);
        check("t36_stall_after", bus.alu_stall, 0);
        nxt(); bus.alu_we = 0;

        // mem and io accepted together: mem written first, then io
        bus.mem_valid = 1; bus.mem_rd = 9;  bus.mem_data = 32'h11;
        bus.io_valid  = 1; bus.io_rd  = 10; bus.io_data  = 32'h22;
        smp(); nxt();
        bus.mem_valid = 0; bus.io_valid = 0;
        smp(); check("t37_io_busy1", bus.io_ready, 0);
        nxt(); smp();
        check("t37_first", bus.rf_waddr, 9);
        check("t37_io_busy2", bus.io_ready, 0);
        nxt(); smp();
        check("t37_second", bus.rf_waddr, 10);
        check("t37_second_we", bus.rf_we, 1);
        check("t37_io_free", bus.io_ready, 1);

        // io write to r0 is consumed without enabling the write
        nxt();
        bus.io_valid = 1; bus.io_rd = 0; bus.io_data = 32'hFFFF;
        smp(); nxt(); bus.io_valid = 0;
        smp(); check("t38_busy", bus.io_ready, 0);
        nxt(); smp();
        check("t38_we", bus.rf_we, 0);
        check("t38_addr", bus.rf_waddr, 0);
        check("t38_data", bus.rf_wdata, 32'hFFFF);
        check("t38_ready", bus.io_ready, 1);

        // Both buffers starve behind a busy ALU
        nxt();
        bus.alu_we = 1; bus.alu_rd = 4; bus.alu_data = 32'h44;
        bus.mem_valid = 1; bus.mem_rd = 12; bus.mem_data = 32'hC;
        bus.io_valid  = 1; bus.io_rd  = 13; bus.io_data  = 32'hD;
        hist = 0; w6 = 0; w7 = 0;
        for (int i = 0; i < 8; i++) begin
            smp();
            hist[i] = bus.alu_stall;
            if (i == 6) w6 = bus.rf_waddr;
            if (i == 7) w7 = bus.rf_waddr;
            nxt();
            bus.mem_valid = 0; bus.io_valid = 0;
        end
        check("t39_stall_pattern", hist, 8'b0110_0000);
        check("t39_mem_first", w6, 12);
        check("t39_io_second", w7, 13);

        // Reset with both buffers full and ALU requesting
        bus.mem_valid = 1; bus.mem_rd = 14; bus.mem_data = 32'hE;
        bus.io_valid  = 1; bus.io_rd  = 15; bus.io_data  = 32'hF;
        smp(); nxt();
        bus.mem_valid = 0; bus.io_valid = 0; reset = 1;
        smp();
        check("t40_stall_rst", bus.alu_stall, 0);
        check("t40_mready_rst", bus.mem_ready, 0);
        check("t40_iready_rst", bus.io_ready, 0);
        nxt(); reset = 0; bus.alu_we = 0;
        smp();
        check("t40_we", bus.rf_we, 0);
        check("t40_addr", bus.rf_waddr, 0);
        check("t40_data", bus.rf_wdata, 0);
        check("t40_mready", bus.mem_ready, 1);
        check("t40_iready", bus.io_ready, 1);
        nxt(); smp();
        check("t40_no_late_write", bus.rf_we, 0);

        // Randomized traffic with requesters holding their payloads
        for (int i = 0; i < 3000; i++) begin
            nxt();
            reset = ($urandom_range(0, 199) == 0);
            if (alu_done) begin
                bus.alu_we   = ($urandom_range(0, 3) != 0);
                bus.alu_rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                bus.alu_data = $urandom;
            end
            if (!(bus.mem_valid && !mem_xfer)) begin
                bus.mem_valid = ($urandom_range(0, 2) == 0);
                bus.mem_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                bus.mem_data  = $urandom;
            end
            if (!(bus.io_valid && !io_xfer)) begin
                bus.io_valid = ($urandom_range(0, 3) == 0);
                bus.io_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                bus.io_data  = $urandom;
            end
        end
        reset = 0; bus.alu_we = 0; bus.mem_valid = 0; bus.io_valid = 0;
        repeat (3) nxt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
